uart_serializer: RTL and testbench

//  Transmit-side stage feeding the 12-bit deserializer's UART_RX input. Accepts a
//  12-bit word over a valid/ready handshake and shifts it out as one serial frame:

---
 rtl/uart_serializer_if.sv | 24 ++
 rtl/uart_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_serializer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_serializer_if.sv
// Word-source handshake between the data producer and uart_serializer.
// The source drives TX_Data/TX_Valid; the serializer answers with TX_Ready/TX_Busy.
interface uart_serializer_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] TX_Data;
  logic              TX_Valid;
  logic              TX_Ready;
  logic              TX_Busy;

  modport master (
    output TX_Data,
    output TX_Valid,
    input  TX_Ready,
    input  TX_Busy
  );

  modport slave (
    input  TX_Data,
    input  TX_Valid,
    output TX_Ready,
    output TX_Busy
  );
endinterface

// File: rtl/uart_serializer.sv
// UART frame serializer: start bit, DATA_W data bits MSB first, optional even parity, stop bits.
// Optional parity bit enabled by defining SERIALIZER_PARITY_EN.
//
// state    | meaning
// S_IDLE   | line high, TX_Ready=1, waiting for accept
// S_START  | line low for one bit period
// S_DATA   | shift register MSB on the line, one bit per period
// S_PARITY | even parity of the captured word (SERIALIZER_PARITY_EN only)
// S_STOP   | line high for STOP_BITS bit periods
module uart_serializer #(
  parameter int DATA_W       = 12,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_serializer_if.slave tx_if,
  output logic             UART_TX
);

  localparam int TMR_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int IDX_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIALIZER_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [TMR_W-1:0]    r_timer;
  logic [TMR_W-1:0]    w_timer_next;
  logic [IDX_W-1:0]    r_bit_idx;
  logic [IDX_W-1:0]    w_bit_idx_next;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   w_shreg_next;
  logic                r_tx;
  logic                w_tx_next;
  logic                r_busy;
  logic                w_busy_next;
  logic                w_accept;
  logic                w_bit_end;
`ifdef SERIALIZER_PARITY_EN
  logic                r_parity;
`endif

  assign w_accept  = tx_if.TX_Valid & (r_state == S_IDLE);
  assign w_bit_end = (r_timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shreg   <= w_shreg_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
`ifdef SERIALIZER_PARITY_EN
      if (w_accept) r_parity <= ^tx_if.TX_Data;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_START;
      S_START:  if (w_bit_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bit_idx == DATA_LAST)) begin
`ifdef SERIALIZER_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`endif
      S_STOP:   if (w_bit_end && (r_bit_idx == STOP_LAST)) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Line value is computed from the next state so UART_TX is a plain flop output.
  always_comb begin
    w_timer_next   = '0;
    w_bit_idx_next = r_bit_idx;
    w_shreg_next   = r_shreg;
    w_tx_next      = 1'b1;
    w_busy_next    = (w_state_next != S_IDLE);

    if ((r_state != S_IDLE) && !w_bit_end) w_timer_next = r_timer + 1'b1;

    if (w_state_next != r_state)
      w_bit_idx_next = '0;
    else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP)))
      w_bit_idx_next = r_bit_idx + 1'b1;

    if (w_accept)
      w_shreg_next = tx_if.TX_Data;
    else if ((r_state == S_DATA) && w_bit_end)
      w_shreg_next = {r_shreg[DATA_W-2:0], 1'b0};

    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shreg_next[DATA_W-1];
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign tx_if.TX_Ready = (r_state == S_IDLE);
  assign tx_if.TX_Busy  = r_busy;
  assign UART_TX        = r_tx;

endmodule

// File: tb/tb_uart_serializer.sv
// Self-checking bench for uart_serializer against a bit-index frame model.
// Follows SERIALIZER_PARITY_EN to expect the parity bit and longer frame.
module tb_uart_serializer;

  localparam int DATA_W = 12;
  localparam int CPB    = 16;
  localparam int SB     = 1;
`ifdef SERIALIZER_PARITY_EN
  localparam int PAR    = 1;
`else
  localparam int PAR    = 0;
`endif
  localparam int NBITS  = 1 + DATA_W + PAR + SB;
  localparam int F      = NBITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;
  int   exp_accepts = 0;

  uart_serializer_if #(.DATA_W(DATA_W)) tx_if ();

  uart_serializer #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tx_if  (tx_if),
    .UART_TX(uart_tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && tx_if.TX_Valid && tx_if.TX_Ready) accepts++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Frame as a list of bit periods: 0 start, 1..DATA_W data MSB first, parity, stop.
  function automatic logic model_bit(input logic [DATA_W-1:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W) return d[DATA_W-idx];
    if ((PAR == 1) && (idx == DATA_W + 1)) return ^d;
    return 1'b1;
  endfunction

  function automatic logic [31:0] line_state();
    return {29'd0, uart_tx, tx_if.TX_Busy, tx_if.TX_Ready};
  endfunction

  // Entered at the falling edge of frame cycle 0; leaves at the first IDLE cycle.
  task automatic check_frame(input logic [DATA_W-1:0] d, input bit disturb);
    for (int k = 0; k < F; k++) begin
      check_eq($sformatf("frame_%03h_c%0d", d, k), line_state(),
               {29'd0, model_bit(d, k / CPB), 1'b1, 1'b0});
      if (disturb && (k == 100)) begin
        tx_if.TX_Data  = DATA_W'($urandom);
        tx_if.TX_Valid = 1'b1;
      end
      if (disturb && (k == 103)) tx_if.TX_Valid = 1'b0;
      @(negedge clk);
    end
    check_eq($sformatf("idle_%03h", d), line_state(), 32'h5);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_if.TX_Ready && (n < 2 * F)) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", 32'(tx_if.TX_Ready), 32'd1);
  endtask

  task automatic accept_word(input logic [DATA_W-1:0] d);
    wait_ready();
    tx_if.TX_Data  = d;
    tx_if.TX_Valid = 1'b1;
    @(posedge clk);
    exp_accepts++;
    @(negedge clk);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit disturb);
    accept_word(d);
    tx_if.TX_Valid = 1'b0;
    tx_if.TX_Data  = DATA_W'($urandom);
    check_frame(d, disturb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w;
    tx_if.TX_Valid = 1'b0;
    tx_if.TX_Data  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_busy", 32'(tx_if.TX_Busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_state", line_state(), 32'h5);

    send(12'hA5C, 1'b0);
    send(12'h000, 1'b0);
    send(12'hFFF, 1'b0);
    send(12'h5A3, 1'b0);

    // Valid held high across two words: second accept lands on the single IDLE cycle.
    accept_word(12'h123);
    tx_if.TX_Data = 12'h456;
    check_frame(12'h123, 1'b0);
    @(posedge clk);
    exp_accepts++;
    @(negedge clk);
    tx_if.TX_Valid = 1'b0;
    check_frame(12'h456, 1'b0);
    check_eq("accepts_b2b", 32'(accepts), 32'(exp_accepts));

    send(12'h3C7, 1'b1);
    check_eq("accepts_disturb", 32'(accepts), 32'(exp_accepts));

    send(12'h001, 1'b0);
    send(12'h003, 1'b0);

    for (int i = 0; i < 6; i++) begin
      w = DATA_W'($urandom);
      send(w, 1'($urandom_range(0, 1)));
    end

    // Reset 100 cycles into a frame, then a clean frame afterwards.
    accept_word(12'h9E1);
    tx_if.TX_Valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      check_eq("pre_rst_frame", line_state(), {29'd0, model_bit(12'h9E1, k / CPB), 1'b1, 1'b0});
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_tx", 32'(uart_tx), 32'd1);
    check_eq("midrst_busy", 32'(tx_if.TX_Busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_midrst", line_state(), 32'h5);
    send(12'h2B4, 1'b0);
    check_eq("accepts_final", 32'(accepts), 32'(exp_accepts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
